// File: rtl/dm_cache_ctrl.sv
// Blocking controller for a 1024-line direct-mapped data cache with 4-word blocks.
// Handles hits in one compare cycle and misses by optional write-back then line fill.
module dm_cache_ctrl (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         cpu_req_valid,
   input  logic         cpu_req_rw,
   input  logic [31:0]  cpu_req_addr,
   input  logic [31:0]  cpu_req_data,
   output logic         cpu_res_ready,
   output logic [31:0]  cpu_res_data,
   output logic         mem_req_valid,
   output logic         mem_req_rw,
   output logic [31:0]  mem_req_addr,
   output logic [127:0] mem_req_data,
   input  logic         mem_data_ready,
   input  logic [127:0] mem_data,
   output logic [9:0]   tag_req_index,
   output logic         tag_req_we,
   output logic [19:0]  tag_write,
   input  logic [19:0]  tag_read,
   output logic [9:0]   data_req_index,
   output logic         data_req_we,
   output logic [127:0] data_write,
   input  logic [127:0] data_read
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      COMPARE    = 2'd1,
      WRITE_BACK = 2'd2,
      ALLOCATE   = 2'd3
   } state_e;

   state_e       state_q, state_d;
   logic         rw_q, rw_d;
   logic [31:2]  addr_q, addr_d;
   logic [31:0]  wdata_q, wdata_d;
   logic [17:0]  victim_tag_q, victim_tag_d;

   logic [17:0]  tag_s;
   logic [9:0]   idx_s;
   logic [1:0]   word_s;
   logic         hit_s;
   logic         victim_dirty_s;
   logic         unused_addr_s;

   function automatic logic [31:0] select_word(input logic [127:0] blk, input logic [1:0] sel);
      logic [31:0] w;
      case (sel)
         2'd0:    w = blk[31:0];
         2'd1:    w = blk[63:32];
         2'd2:    w = blk[95:64];
         2'd3:    w = blk[127:96];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   function automatic logic [127:0] merge_word(input logic [127:0] blk, input logic [1:0] sel,
                                               input logic [31:0] w);
      logic [127:0] r;
      r = blk;
      case (sel)
         2'd0:    r[31:0]   = w;
         2'd1:    r[63:32]  = w;
         2'd2:    r[95:64]  = w;
         2'd3:    r[127:96] = w;
         default: r = blk;
      endcase
      return r;
   endfunction

   assign tag_s          = addr_q[31:14];
   assign idx_s          = addr_q[13:4];
   assign word_s         = addr_q[3:2];
   assign hit_s          = tag_read[19] && (tag_read[17:0] == tag_s);
   assign victim_dirty_s = tag_read[19] && tag_read[18];
   // Byte offset within a word plays no part in a word-granular cache.
   assign unused_addr_s  = ^cpu_req_addr[1:0];

   // State and latched request registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         rw_q         <= 1'b0;
         addr_q       <= 30'd0;
         wdata_q      <= 32'd0;
         victim_tag_q <= 18'd0;
      end else begin
         state_q      <= state_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         victim_tag_q <= victim_tag_d;
      end
   end

   // Next-state and request/victim capture.
   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      victim_tag_d = victim_tag_q;
      case (state_q)
         IDLE: begin
            if (cpu_req_valid) begin
               state_d = COMPARE;
               rw_d    = cpu_req_rw;
               addr_d  = cpu_req_addr[31:2];
               wdata_d = cpu_req_data;
            end else begin
               state_d = IDLE;
            end
         end
         COMPARE: begin
            if (hit_s) begin
               state_d = IDLE;
            end else if (victim_dirty_s) begin
               state_d      = WRITE_BACK;
               victim_tag_d = tag_read[17:0];
            end else begin
               state_d = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            if (mem_data_ready) begin
               state_d = ALLOCATE;
            end else begin
               state_d = WRITE_BACK;
            end
         end
         ALLOCATE: begin
            if (mem_data_ready) begin
               state_d = COMPARE;
            end else begin
               state_d = ALLOCATE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state and the latched request.
   always_comb begin
      cpu_res_ready  = 1'b0;
      cpu_res_data   = 32'd0;
      mem_req_valid  = 1'b0;
      mem_req_rw     = 1'b0;
      mem_req_addr   = 32'd0;
      mem_req_data   = 128'd0;
      tag_req_index  = idx_s;
      tag_req_we     = 1'b0;
      tag_write      = 20'd0;
      data_req_index = idx_s;
      data_req_we    = 1'b0;
      data_write     = 128'd0;
      case (state_q)
         IDLE: begin
            // Gated so that every output reads zero while reset is held.
            if (rst_ni) begin
               tag_req_index  = cpu_req_addr[13:4];
               data_req_index = cpu_req_addr[13:4];
            end else begin
               tag_req_index  = 10'd0;
               data_req_index = 10'd0;
            end
         end
         COMPARE: begin
            if (hit_s) begin
               cpu_res_ready = 1'b1;
               if (rw_q) begin
                  tag_req_we  = 1'b1;
                  tag_write   = {1'b1, 1'b1, tag_s};
                  data_req_we = 1'b1;
                  data_write  = merge_word(data_read, word_s, wdata_q);
               end else begin
                  cpu_res_data = select_word(data_read, word_s);
               end
            end else begin
               cpu_res_ready = 1'b0;
            end
         end
         WRITE_BACK: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {victim_tag_q, idx_s, 4'b0000};
            mem_req_data  = data_read;
         end
         ALLOCATE: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b0;
            mem_req_addr  = {tag_s, idx_s, 4'b0000};
            if (mem_data_ready) begin
               data_req_we = 1'b1;
               data_write  = mem_data;
               tag_req_we  = 1'b1;
               tag_write   = {1'b1, 1'b0, tag_s};
            end else begin
               data_req_we = 1'b0;
               tag_req_we  = 1'b0;
            end
         end
         default: begin
            cpu_res_ready = 1'b0;
         end
      endcase
   end

endmodule
